serial_adder_controller: RTL and testbench

- Bit-serial adder that shares one existing `full_adder` instance across all bits of a WIDTH-bit operand pair.
- Sequences the adder LSB-first, one bit per clock, with shift registers and a registered carry.
- Uses a valid/ready handshake on input and output.
- Intended as the area-minimal add unit for narrow datapaths; it is also the first clocked consumer of `full_adder`.

---
 rtl/serial_adder_controller_if.sv | 29 ++
 rtl/serial_adder_controller.sv | 127 ++++++++++++
 tb/tb_serial_adder_controller.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_controller_if.sv
// Handshake and data bundle for the bit-serial adder: operand side
// (in_valid/in_ready, a, b, carry_in) and result side (out_valid/out_ready,
// sum, carry_out) plus the busy status flag.
interface serial_adder_controller_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             busy;

  // Producer/consumer side of the adder.
  modport master (
    output in_valid, a, b, carry_in, out_ready,
    input  in_ready, out_valid, sum, carry_out, busy
  );

  // The adder itself.
  modport slave (
    input  in_valid, a, b, carry_in, out_ready,
    output in_ready, out_valid, sum, carry_out, busy
  );
endinterface

// File: rtl/serial_adder_controller.sv
// Bit-serial adder: one shared full_adder cell walks a WIDTH-bit operand pair
// LSB-first, one bit per clock, with a registered carry between bits.
// Results are held under backpressure until the consumer takes them.

// Single-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);
  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (carry_in & (a ^ b));
endmodule

// State table:
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   RUN   | one bit per edge through the full adder
//   DONE  | result presented, held until out_ready
module serial_adder_controller #(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  serial_adder_controller_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry_q;
  logic [CW-1:0]    bit_cnt;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH:0]   sum_cat;

  // The only arithmetic in the block; every bit goes through this cell.
  full_adder u_full_adder (
    .a         (a_sh[0]),
    .b         (b_sh[0]),
    .carry_in  (carry_q),
    .sum       (fa_sum),
    .carry_out (fa_carry)
  );

  // New sum bit enters at the MSB while the accumulated bits move down;
  // written as a slice of a concatenation so WIDTH=1 needs no special case.
  assign sum_cat = {fa_sum, sum_sh};

  // Sequencer, shift datapath and registered handshake outputs in one block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      sum_sh      <= '0;
      carry_q     <= 1'b0;
      bit_cnt     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh       <= bus.a;
            b_sh       <= bus.b;
            carry_q    <= bus.carry_in;
            sum_sh     <= '0;
            bit_cnt    <= '0;
            state      <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          sum_sh  <= sum_cat[WIDTH:1];
          carry_q <= fa_carry;
          bit_cnt <= bit_cnt + CW'(1);
          if (bit_cnt == LAST_BIT) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          // Result registers are untouched here so backpressure can last forever.
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  // Partial sums never leak out: outputs read as zero unless a result is valid.
  assign bus.sum       = out_valid_q ? sum_sh : '0;
  assign bus.carry_out = out_valid_q & carry_q;
endmodule

// File: tb/tb_serial_adder_controller.sv
// Randomized and directed bench for serial_adder_controller at WIDTH=8 and
// WIDTH=3, checked against plain integer addition.
module tb_serial_adder_controller;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  serial_adder_controller_if #(.WIDTH(8)) if8 ();
  serial_adder_controller_if #(.WIDTH(3)) if3 ();

  serial_adder_controller #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(if8));
  serial_adder_controller #(.WIDTH(3)) dut3 (.clk(clk), .reset(reset), .bus(if3));

  int total  = 0;
  int passed = 0;
  logic sel3 = 1'b0;

  logic       obs_ov, obs_ir, obs_busy, obs_cout;
  logic [7:0] obs_sum;

  // Observe whichever instance the current test is driving.
  always_comb begin
    if (sel3) begin
      obs_ov = if3.out_valid; obs_ir = if3.in_ready; obs_busy = if3.busy;
      obs_cout = if3.carry_out; obs_sum = {5'b0, if3.sum};
    end else begin
      obs_ov = if8.out_valid; obs_ir = if8.in_ready; obs_busy = if8.busy;
      obs_cout = if8.carry_out; obs_sum = if8.sum;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic cin);
    if (sel3) begin
      if3.in_valid = v; if3.a = a[2:0]; if3.b = b[2:0]; if3.carry_in = cin;
    end else begin
      if8.in_valid = v; if8.a = a; if8.b = b; if8.carry_in = cin;
    end
  endtask

  task automatic set_ready(input logic r);
    if (sel3) if3.out_ready = r;
    else      if8.out_ready = r;
  endtask

  // One full transaction on the selected instance, checked against a+b+cin.
  task automatic do_add(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input bit early);
    int w, mask, e, n;
    bit busy_bad;
    w = sel3 ? 3 : 8;
    mask = (1 << w) - 1;
    e = (int'(a) & mask) + (int'(b) & mask) + int'(cin);
    busy_bad = 0;

    total++;
    if (obs_ir !== 1'b1) $display("FAIL %s in_ready_before got %b exp 1", name, obs_ir);
    else passed++;

    drive(1'b1, a, b, cin);
    set_ready(early);
    tick();
    // Garbage on the operand bus during RUN must not disturb the result.
    drive(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    n = 0;
    while (!obs_ov && n < 40) begin
      if (!obs_busy || obs_ir) busy_bad = 1;
      tick();
      n++;
    end

    total++;
    if (n != w) $display("FAIL %s latency got %0d exp %0d", name, n, w);
    else passed++;
    total++;
    if (int'(obs_sum) != (e & mask)) $display("FAIL %s sum got %0h exp %0h", name, obs_sum, e & mask);
    else passed++;
    total++;
    if (obs_cout !== 1'((e >> w) & 1)) $display("FAIL %s carry_out got %b exp %0d", name, obs_cout, (e >> w) & 1);
    else passed++;
    total++;
    if (busy_bad || obs_busy !== 1'b1 || obs_ir !== 1'b0)
      $display("FAIL %s busy_run got busy=%b in_ready=%b exp busy=1 in_ready=0", name, obs_busy, obs_ir);
    else passed++;

    set_ready(1'b1);
    tick();
    set_ready(1'b0);
    total++;
    if (obs_ov !== 1'b0 || obs_ir !== 1'b1 || obs_busy !== 1'b0 || obs_sum !== 8'h00)
      $display("FAIL %s back_to_idle got ov=%b ir=%b busy=%b sum=%0h exp 0 1 0 0", name, obs_ov, obs_ir, obs_busy, obs_sum);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    sel3 = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0); set_ready(1'b0);
    sel3 = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 1'b0); set_ready(1'b0);
    sel3 = 1'b0;
    #1 reset = 1'b1;
    #3;
    total++;
    if (if8.out_valid !== 1'b0 || if8.sum !== 8'h00 || if8.carry_out !== 1'b0 || if8.busy !== 1'b0 || if8.in_ready !== 1'b1)
      $display("FAIL reset8 got ov=%b sum=%0h co=%b busy=%b ir=%b exp 0 0 0 0 1",
               if8.out_valid, if8.sum, if8.carry_out, if8.busy, if8.in_ready);
    else passed++;
    total++;
    if (if3.out_valid !== 1'b0 || if3.sum !== 3'h0 || if3.busy !== 1'b0 || if3.in_ready !== 1'b1)
      $display("FAIL reset3 got ov=%b sum=%0h busy=%b ir=%b exp 0 0 0 1", if3.out_valid, if3.sum, if3.busy, if3.in_ready);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    sel3 = 1'b0;
    do_add("basic", 8'h5A, 8'h3C, 1'b0, 0);
  endtask

  task automatic test_carry_wrap();
    sel3 = 1'b0;
    do_add("wrap", 8'hFF, 8'h01, 1'b0, 0);
    do_add("max", 8'hFF, 8'hFF, 1'b1, 0);
  endtask

  // Random operands; some transactions raise out_ready early (during RUN).
  task automatic test_random();
    sel3 = 1'b0;
    for (int i = 0; i < 16; i++)
      do_add("random", 8'($urandom), 8'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
  endtask

  task automatic test_backpressure();
    logic [7:0] a, b;
    logic cin;
    int e, n;
    sel3 = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    e = int'(a) + int'(b) + int'(cin);
    drive(1'b1, a, b, cin);
    tick();
    drive(1'b0, a, b, cin);
    n = 0;
    while (!obs_ov && n < 40) begin tick(); n++; end
    for (int c = 0; c < 5; c++) begin
      total++;
      if (obs_ov !== 1'b1 || int'(obs_sum) != (e & 255) || obs_cout !== 1'(e >> 8) || obs_ir !== 1'b0)
        $display("FAIL bp_hold%0d got ov=%b sum=%0h co=%b ir=%b exp 1 %0h %0d 0", c, obs_ov, obs_sum, obs_cout, obs_ir, e & 255, e >> 8);
      else passed++;
      if (c == 2) drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
      else drive(1'b0, a, b, cin);
      tick();
    end
    drive(1'b0, a, b, cin);
    set_ready(1'b1);
    tick();
    set_ready(1'b0);
    total++;
    if (obs_ir !== 1'b1 || obs_ov !== 1'b0) $display("FAIL bp_release got ir=%b ov=%b exp 1 0", obs_ir, obs_ov);
    else passed++;
    tick();
    total++;
    if (obs_busy !== 1'b0) $display("FAIL bp_ignored_pulse got busy=%b exp 0", obs_busy);
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit ov_seen;
    sel3 = 1'b0;
    drive(1'b1, 8'hAA, 8'h55, 1'b0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) tick();
    #1 reset = 1'b1;
    #1;
    total++;
    if (obs_ov !== 1'b0 || obs_sum !== 8'h00 || obs_busy !== 1'b0 || obs_ir !== 1'b1)
      $display("FAIL reset_run got ov=%b sum=%0h busy=%b ir=%b exp 0 0 0 1", obs_ov, obs_sum, obs_busy, obs_ir);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    ov_seen = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (obs_ov) ov_seen = 1;
    end
    total++;
    if (ov_seen) $display("FAIL reset_run_no_pulse got out_valid=1 exp 0");
    else passed++;
    do_add("after_reset", 8'h01, 8'h01, 1'b0, 0);

    // Reset while a result is being held in DONE.
    drive(1'b1, 8'hC3, 8'h7E, 1'b1);
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    repeat (10) tick();
    #1 reset = 1'b1;
    #1;
    total++;
    if (obs_ov !== 1'b0 || obs_sum !== 8'h00 || obs_cout !== 1'b0 || obs_busy !== 1'b0)
      $display("FAIL reset_done got ov=%b sum=%0h co=%b busy=%b exp 0 0 0 0", obs_ov, obs_sum, obs_cout, obs_busy);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_exhaustive();
    logic [6:0] idx;
    sel3 = 1'b1;
    for (int i = 0; i < 128; i++) begin
      idx = 7'(i);
      do_add("exh3", {5'b0, idx[2:0]}, {5'b0, idx[5:3]}, idx[6], 0);
    end
    sel3 = 1'b0;
  endtask

  task automatic test_back_to_back();
    int q[$];
    logic [7:0] a, b;
    logic cin;
    int results, last, cyc, e, k;
    bit gap_bad, dup_bad, acc, done;
    sel3 = 1'b0;
    results = 0; last = -1; cyc = 0; gap_bad = 0; dup_bad = 0;
    set_ready(1'b1);
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    drive(1'b1, a, b, cin);
    while (results < 6 && cyc < 200) begin
      acc = obs_ir; done = obs_ov;
      if (done) begin
        if (q.size() == 0) dup_bad = 1;
        else begin
          e = q.pop_front();
          total++;
          if (int'({obs_cout, obs_sum}) != e) $display("FAIL b2b_result got %0h exp %0h", {obs_cout, obs_sum}, e);
          else passed++;
        end
        if (last >= 0 && cyc - last != 10) gap_bad = 1;
        last = cyc;
        results++;
      end
      if (acc) q.push_back(int'(a) + int'(b) + int'(cin));
      tick();
      cyc++;
      if (acc) begin
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        drive(1'b1, a, b, cin);
      end
    end
    drive(1'b0, a, b, cin);
    k = 0;
    while ((obs_busy || q.size() > 0) && k < 40) begin
      if (obs_ov) begin
        if (q.size() == 0) dup_bad = 1;
        else begin
          e = q.pop_front();
          total++;
          if (int'({obs_cout, obs_sum}) != e) $display("FAIL b2b_drain got %0h exp %0h", {obs_cout, obs_sum}, e);
          else passed++;
        end
      end
      tick();
      k++;
    end
    set_ready(1'b0);
    total++;
    if (results != 6) $display("FAIL b2b_count got %0d exp 6", results);
    else passed++;
    total++;
    if (gap_bad) $display("FAIL b2b_interval got irregular spacing exp 10 cycles");
    else passed++;
    total++;
    if (dup_bad || q.size() != 0) $display("FAIL b2b_integrity got dup=%b pending=%0d exp 0 0", dup_bad, q.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_wrap();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_exhaustive();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
